// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared data width, default sizing, requester-ID type and one-hot decode
package mult_arb_pkg;
    localparam int DATA_W = 64;
    localparam int NREQ_DEF = 4;
    localparam int TAGDEPTH_DEF = 64;
    localparam int MAX_NREQ = 8;
    localparam int TAG_MAX_W = $clog2(MAX_NREQ);
    // Wide enough for any legal NREQ, so one queue entry type serves every build.
    typedef logic [TAG_MAX_W-1:0] tag_t;
    function automatic tag_t onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < MAX_NREQ; i++)
            if (oh[i]) onehot_to_idx = tag_t'(i);
    endfunction
endpackage

// File: rtl/mult_arb_rr_arb.sv
// rr_arb: N-way round-robin arbiter; the search starts just after ptr and wraps at N
module rr_arb
    import mult_arb_pkg::*;
#(
    parameter int N = NREQ_DEF,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);
    logic [N-1:0] w_gnt;
    logic [W-1:0] w_k;
    always_comb begin
        w_gnt = '0;
        w_k = '0;
        for (int i = 1; i <= N; i++) begin
            w_k = W'((int'(ptr) + i) % N);
            if (en && w_gnt == '0 && req[w_k]) w_gnt[w_k] = 1'b1;
        end
    end
    assign gnt = w_gnt;
    assign gnt_idx = W'(onehot_to_idx(MAX_NREQ'(w_gnt)));
endmodule

// File: rtl/mult_arb.sv
// mult_arb: shares one multiplier among NREQ requesters, returning results in issue order by tag
// Defining MULT_ARB_ERRCHK_EN adds the sticky err flag and protocol assertions.
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int TAGDEPTH = TAGDEPTH_DEF,
    parameter int TAGW = $clog2(NREQ)
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_vld,
    input  logic [NREQ*DATA_W-1:0]        req_a,
    input  logic [NREQ*DATA_W-1:0]        req_b,
    output logic [NREQ-1:0]               req_rdy,
    output logic [DATA_W-1:0]             m_a,
    output logic [DATA_W-1:0]             m_b,
    output logic                          m_vld,
    input  logic                          m_rdy,
    input  logic [DATA_W-1:0]             m_res,
    input  logic                          m_res_vld,
    output logic [NREQ-1:0]               rsp_vld,
    output logic [DATA_W-1:0]             rsp_res,
    output logic [$clog2(TAGDEPTH+1)-1:0] outstanding,
    output logic                          err
);
    localparam int CW = $clog2(TAGDEPTH + 1);
    localparam int AW = TAGDEPTH > 1 ? $clog2(TAGDEPTH) : 1;
    logic [TAGW-1:0] r_ptr, w_gnt_idx;
    logic [AW-1:0] r_wp, r_rp;
    tag_t r_q [TAGDEPTH];
    logic w_can_issue, w_push, w_pop;
    assign w_can_issue = m_rdy && outstanding < CW'(TAGDEPTH);
    assign w_push = |req_rdy;
    // The in-flight count doubles as the tag-queue occupancy; results with nothing queued are dropped.
    assign w_pop = m_res_vld && outstanding != '0;
    rr_arb #(.N(NREQ), .W(TAGW)) u_rr (
        .req(req_vld),
        .en(w_can_issue),
        .ptr(r_ptr),
        .gnt(req_rdy),
        .gnt_idx(w_gnt_idx)
    );
    always_ff @(posedge ck) begin
        if (rst) begin
            m_a <= '0;
            m_b <= '0;
            m_vld <= 1'b0;
            rsp_vld <= '0;
            rsp_res <= '0;
            outstanding <= '0;
            r_ptr <= TAGW'(NREQ - 1);
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            m_vld <= w_push;
            if (w_push) begin
                m_a <= req_a[DATA_W*w_gnt_idx +: DATA_W];
                m_b <= req_b[DATA_W*w_gnt_idx +: DATA_W];
                r_ptr <= w_gnt_idx;
                r_wp <= r_wp == AW'(TAGDEPTH - 1) ? '0 : r_wp + 1'b1;
            end
            rsp_vld <= w_pop ? NREQ'(1) << r_q[r_rp] : '0;
            if (w_pop) begin
                rsp_res <= m_res;
                r_rp <= r_rp == AW'(TAGDEPTH - 1) ? '0 : r_rp + 1'b1;
            end
            outstanding <= outstanding + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge ck)
        if (w_push) r_q[r_wp] <= tag_t'(w_gnt_idx);
`ifdef MULT_ARB_ERRCHK_EN
    logic r_m_rdy_d;
    always_ff @(posedge ck) begin
        if (rst) begin
            err <= 1'b0;
            r_m_rdy_d <= 1'b0;
        end else begin
            r_m_rdy_d <= m_rdy;
            err <= err | (m_res_vld && outstanding == '0) | (m_vld && !r_m_rdy_d) |
                   (outstanding > CW'(TAGDEPTH));
        end
    end
    a_res_empty: assert property (@(posedge ck) disable iff (rst) !(m_res_vld && outstanding == '0))
        else $warning("mult_arb: result arrived with empty tag queue");
    a_issue_rdy: assert property (@(posedge ck) disable iff (rst) !(m_vld && !r_m_rdy_d))
        else $warning("mult_arb: issue while multiplier was not ready");
    a_depth: assert property (@(posedge ck) disable iff (rst) outstanding <= CW'(TAGDEPTH))
        else $warning("mult_arb: outstanding above tag depth");
`else
    assign err = 1'b0;
`endif
endmodule
